// File: rtl/fixed_point_sub_pipe_if.sv
// Handshake bundle for the sign-magnitude subtractor pipe.
// The master side drives operands and out_ready; the slave side (the pipe) drives results.
interface fixed_point_sub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_c;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_c, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_c, out_ovf
  );
endinterface

// File: rtl/fixed_point_sub_pipe.sv
// Two-stage sign-magnitude subtractor C = A - B with valid/ready on both sides.
// Define FXP_SUB_SAT_EN to clamp overflowed magnitudes instead of wrapping them.
module fixed_point_sub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  fixed_point_sub_pipe_if.slave bus
);
  localparam int MW = WIDTH - 1;

  logic          s1_valid;
  logic          s1_sign;
  logic          s1_sub;
  logic [MW-1:0] s1_big;
  logic [MW-1:0] s1_small;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_c;
  logic             s2_ovf;

  logic          s1_adv;
  logic          s2_adv;

  logic [MW-1:0] mag_a;
  logic [MW-1:0] mag_b;
  logic          sign_a;
  logic          sign_b_eff;
  logic          a_ge;
  logic          eff_sub;
  logic [MW-1:0] big_n;
  logic [MW-1:0] small_n;
  logic          sign_n;

  logic [MW:0]   raw;
  logic          ovf_n;
  logic [MW-1:0] mag_res;
  logic          sign_res;

  assign s2_adv      = ~s2_valid | bus.out_ready;
  assign s1_adv      = ~s1_valid | s2_adv;
  assign bus.in_ready = ~rst & s1_adv;

  assign bus.out_valid = s2_valid;
  assign bus.out_c     = s2_c;
  assign bus.out_ovf   = s2_ovf;

  // Subtraction becomes addition of A and B with B's sign flipped.
  always_comb begin
    mag_a      = bus.in_a[MW-1:0];
    mag_b      = bus.in_b[MW-1:0];
    sign_a     = bus.in_a[MW];
    sign_b_eff = ~bus.in_b[MW];
    a_ge       = (mag_a >= mag_b);
    eff_sub    = sign_a ^ sign_b_eff;
    big_n      = a_ge ? mag_a : mag_b;
    small_n    = a_ge ? mag_b : mag_a;
    sign_n     = (eff_sub && !a_ge) ? sign_b_eff : sign_a;
  end

  always_comb begin
    raw = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                 : ({1'b0, s1_big} + {1'b0, s1_small});
    ovf_n = ~s1_sub & raw[MW];
`ifdef FXP_SUB_SAT_EN
    mag_res = ovf_n ? {MW{1'b1}} : raw[MW-1:0];
`else
    mag_res = raw[MW-1:0];
`endif
    // A zero magnitude never carries a sign, including a wrapped overflow.
    sign_res = s1_sign & (|mag_res);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sub   <= 1'b0;
      s1_big   <= '0;
      s1_small <= '0;
      s2_valid <= 1'b0;
      s2_c     <= '0;
      s2_ovf   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sign  <= sign_n;
          s1_sub   <= eff_sub;
          s1_big   <= big_n;
          s1_small <= small_n;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_c   <= {sign_res, mag_res};
          s2_ovf <= ovf_n;
        end
      end
    end
  end
endmodule
